// File: rtl/zero_count_arbiter.sv
// Round-robin arbiter sharing one bit-serial zero counter between two
// requesters; one bit is scanned per clock, LSB first.
module zero_count_arbiter #(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pick1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    count_d = count_q;
    idx_d   = idx_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    // requester 1 wins when alone, or on contention when 0 went last
    pick1   = req1 & (~req0 | ~last_q);
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt1    = pick1;
          gnt0    = ~pick1;
          shift_d = pick1 ? data1 : data0;
          acc_d   = '0;
          idx_d   = '0;
          last_d  = pick1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q + CNT_W'(~shift_q[0]);
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = DONE;
          count_d = acc_d;
          id_d    = last_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = id_q;
  assign count   = count_q;

endmodule

// File: tb/tb_zero_count_arbiter.sv
// Scoreboard bench for zero_count_arbiter: queued requesters, a
// cycle-level reference of the arbiter, and a done monitor.
module tb_zero_count_arbiter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [DATA_W-1:0] data0 = '0;
  logic [DATA_W-1:0] data1 = '0;
  logic              gnt0, gnt1, busy, done, done_id;
  logic [CNT_W-1:0]  count;

  typedef struct {
    int id;
    int cnt;
    int due;
  } exp_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] dq0[$];
  logic [DATA_W-1:0] dq1[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int m_rem = 0;
  int m_last = 1;
  int m_win;
  int held_cnt = 0;
  int held_id = 0;
  bit exp_done;
  bit g0_seen = 0;
  bit g1_seen = 0;
  exp_t e;

  zero_count_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0),
    .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .done(done),
    .done_id(done_id), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Requesters: present the head of their queue until it is granted.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req0 = 1'b0;
      req1 = 1'b0;
      g0_seen = 0;
      g1_seen = 0;
    end else begin
      if (g0_seen) begin
        void'(dq0.pop_front());
        g0_seen = 0;
      end
      if (g1_seen) begin
        void'(dq1.pop_front());
        g1_seen = 0;
      end
      if (dq0.size() > 0) begin
        req0 = 1'b1;
        data0 = dq0[0];
      end else begin
        req0 = 1'b0;
        data0 = ~data0;
      end
      if (dq1.size() > 0) begin
        req1 = 1'b1;
        data1 = dq1[0];
      end else begin
        req1 = 1'b0;
        data1 = ~data1;
      end
    end
  end

  // Reference arbiter + done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rem = 0;
      m_last = 1;
      held_cnt = 0;
      held_id = 0;
      sbq.delete();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_done_id", done_id, 0);
    end else begin
      m_win = -1;
      if (m_rem == 0) begin
        if (req0 && req1) m_win = (m_last == 1) ? 0 : 1;
        else if (req0) m_win = 0;
        else if (req1) m_win = 1;
      end
      chk("gnt0", gnt0, m_win == 0);
      chk("gnt1", gnt1, m_win == 1);
      chk("busy", busy, m_rem > 0);
      exp_done = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("done", done, exp_done);
      if (done && exp_done) begin
        e = sbq.pop_front();
        chk("done_id", done_id, e.id);
        chk("count", count, e.cnt);
        held_cnt = e.cnt;
        held_id = e.id;
      end else if (!done) begin
        chk("hold_count", count, held_cnt);
        chk("hold_done_id", done_id, held_id);
      end
      if (m_rem > 0) m_rem--;
      if (m_win >= 0) begin
        m_last = m_win;
        m_rem = DATA_W + 1;
        e.id = m_win;
        e.cnt = DATA_W - $countones(m_win == 1 ? data1 : data0);
        e.due = cyc + DATA_W + 1;
        sbq.push_back(e);
        if (m_win == 0) g0_seen = 1;
        else g1_seen = 1;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dq0.size() > 0 || dq1.size() > 0 || sbq.size() > 0 ||
            req0 || req1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk("idle_timeout", n >= 3000, 0);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_count", count, 0);
    chk("async_done_id", done_id, 0);
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    do_reset(3);

    dq0.push_back(8'h00);
    wait_idle();

    dq1.push_back(8'hFF);
    dq1.push_back(8'hA5);
    dq1.push_back(8'h01);
    wait_idle();

    do_reset(2);
    dq0.push_back(8'hF0);
    dq1.push_back(8'h0F);
    wait_idle();

    for (int i = 0; i < 3; i++) begin
      dq0.push_back(DATA_W'($urandom));
      dq1.push_back(DATA_W'($urandom));
    end
    wait_idle();

    dq0.push_back(8'h00);
    begin
      int n;
      n = 0;
      while (!busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("run_start_timeout", n >= 50, 0);
    end
    repeat (3) @(negedge clk);
    #1;
    do_reset(2);
    repeat (15) @(negedge clk);
    #1;
    dq0.push_back(8'h00);
    wait_idle();

    repeat (20) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0 && dq0.size() < 3)
        dq0.push_back(DATA_W'($urandom));
      if ($urandom_range(0, 3) == 0 && dq1.size() < 3)
        dq1.push_back(DATA_W'($urandom));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
